rcv_cmd_asm: RTL

- Parametrised successor to the fixed 3-byte receive state machine.
- Assembles NUM_BYTES serial bytes, MSB byte first, into one command word, and holds that word in internal storage.
- Drives a sticky cmd_rdy/clear handshake and per-byte enables.
- Adds inter-byte timeout resync and overrun detection.
- Sits between the UART receiver (rx_rdy/rx_data) and the command processor.

---
 rtl/rcv_cmd_asm.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rcv_cmd_asm.sv
// +--------------------------------------------------------------------------+
// | rcv_cmd_asm: packs NUM_BYTES received bytes (MSB byte first) into one     |
// | command word with a sticky ready/clear handshake, timeout and overrun.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rcv_cmd_asm #(
  parameter int NUM_BYTES   = 3,
  parameter int BYTE_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_rdy,
  input  logic [BYTE_W-1:0]           rx_data,
  input  logic                        clr_cmd_rdy,
  output logic [NUM_BYTES*BYTE_W-1:0] cmd,
  output logic                        cmd_rdy,
  output logic [NUM_BYTES-1:0]        byte_en,
  output logic                        last_byte,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int CMD_W = NUM_BYTES * BYTE_W;
  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RCV  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               cmd_rdy_q, cmd_rdy_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;
  logic               done;

  // Slot index counts down from the MSB byte as idx counts up.
  always_comb begin
    byte_en = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      byte_en[i] = rx_rdy & ~rst & (idx_q == IDX_W'(NUM_BYTES - 1 - i));
    end
  end

  assign last_byte = rx_rdy & (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    done        = 1'b0;

    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_en[i]) begin
        cmd_d[i*BYTE_W +: BYTE_W] = rx_data;
      end
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_rdy) begin
          state_d = RCV;
          idx_d   = IDX_W'(1);
        end
      end
      RCV: begin
        if (rx_rdy) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done    = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (cnt_q == CNT_MAX) begin
          // Stale partial frame: drop it, leave written slots as they are.
          state_d     = IDLE;
          idx_d       = '0;
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // A completing frame beats a same-edge clear.
    if (done) begin
      cmd_rdy_d = 1'b1;
    end else if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end

    if (done && cmd_rdy_q && !clr_cmd_rdy) begin
      overrun_d = 1'b1;
    end else if (clr_cmd_rdy) begin
      overrun_d = 1'b0;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire
